// File: rtl/tlb_op_ctrl_if.sv
// Request/completion handshake between the execute stage and the TLB op sequencer.
interface tlb_op_ctrl_if #(
    parameter int unsigned IW = 5
);
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [4:0]    req_inv_op;
    logic [9:0]    req_inv_asid;
    logic [31:0]   req_inv_vaddr;

    logic          done_valid;
    logic [2:0]    done_op;
    logic          done_hit;
    logic [IW-1:0] done_index;
    logic          done_excp;

    modport master (
        output req_valid, req_op, req_inv_op, req_inv_asid, req_inv_vaddr,
        input  req_ready, done_valid, done_op, done_hit, done_index, done_excp
    );

    modport slave (
        input  req_valid, req_op, req_inv_op, req_inv_asid, req_inv_vaddr,
        output req_ready, done_valid, done_op, done_hit, done_index, done_excp
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB with TLBFILL index generator.
// Define TLB_FILL_LFSR_EN for an LFSR fill index; default is a round-robin counter.
module tlb_op_ctrl #(
    parameter int unsigned TLBNUM = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    tlb_op_ctrl_if.slave              op_if,
    input  logic                      flush,
    input  logic [$clog2(TLBNUM)-1:0] csr_index,
    input  logic                      csr_ne,
    input  logic                      csr_refill,
    input  logic [18:0]               csr_vpn2,
    input  logic [9:0]                csr_asid,
    output logic                      tlb_we,
    output logic                      tlb_fill_mode,
    output logic [$clog2(TLBNUM)-1:0] tlb_w_index,
    output logic [$clog2(TLBNUM)-1:0] tlb_f_index,
    output logic                      tlb_w_e,
    output logic [$clog2(TLBNUM)-1:0] tlb_r_index,
    output logic                      tlb_check_mode,
    output logic [18:0]               tlb_s_vpn2,
    output logic [9:0]                tlb_s_asid,
    output logic [2:0]                tlb_clear_mem,
    output logic [31:0]               tlb_clear_vaddr,
    output logic [9:0]                tlb_clear_asid,
    input  logic                      tlb_rs_e,
    input  logic [$clog2(TLBNUM)-1:0] tlb_s_index
);
    localparam int unsigned IW = $clog2(TLBNUM);
`ifdef TLB_FILL_LFSR_EN
    localparam int unsigned FW = 8;
`else
    localparam int unsigned FW = IW;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    logic [1:0]    state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic [2:0]    op_q, op_d;
    logic          excp_q, excp_d;
    logic          we_q, we_d;
    logic          fill_mode_q, fill_mode_d;
    logic [IW-1:0] w_index_q, w_index_d;
    logic [IW-1:0] f_index_q, f_index_d;
    logic          w_e_q, w_e_d;
    logic [IW-1:0] r_index_q, r_index_d;
    logic          check_mode_q, check_mode_d;
    logic [18:0]   s_vpn2_q, s_vpn2_d;
    logic [9:0]    s_asid_q, s_asid_d;
    logic [2:0]    clear_mem_q, clear_mem_d;
    logic [31:0]   clear_vaddr_q, clear_vaddr_d;
    logic [9:0]    clear_asid_q, clear_asid_d;
    logic          done_valid_q, done_valid_d;
    logic [2:0]    done_op_q, done_op_d;
    logic          done_hit_q, done_hit_d;
    logic [IW-1:0] done_index_q, done_index_d;
    logic          done_excp_q, done_excp_d;
    logic [FW-1:0] fill_q, fill_d;

    // Next-state and next-output logic; TLB strobes are only ever set for the EXEC cycle.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        excp_d        = excp_q;
        we_d          = 1'b0;
        fill_mode_d   = 1'b0;
        check_mode_d  = 1'b0;
        clear_mem_d   = 3'd0;
        w_index_d     = w_index_q;
        f_index_d     = f_index_q;
        w_e_d         = w_e_q;
        r_index_d     = r_index_q;
        s_vpn2_d      = s_vpn2_q;
        s_asid_d      = s_asid_q;
        clear_vaddr_d = clear_vaddr_q;
        clear_asid_d  = clear_asid_q;
        done_valid_d  = 1'b0;
        done_op_d     = 3'd0;
        done_hit_d    = 1'b0;
        done_index_d  = '0;
        done_excp_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_if.req_valid && req_ready_q && !flush) begin
                    state_d = S_EXEC;
                    op_d    = op_if.req_op;
                    excp_d  = (op_if.req_op == OP_INV) && (op_if.req_inv_op > 5'd6);
                    case (op_if.req_op)
                        OP_SRCH: begin
                            check_mode_d = 1'b1;
                            s_vpn2_d     = csr_vpn2;
                            s_asid_d     = csr_asid;
                        end
                        OP_RD: r_index_d = csr_index;
                        OP_WR: begin
                            we_d      = 1'b1;
                            w_index_d = csr_index;
                            w_e_d     = csr_refill | ~csr_ne;
                        end
                        OP_FILL: begin
                            we_d        = 1'b1;
                            fill_mode_d = 1'b1;
                            f_index_d   = fill_q[IW-1:0];
                            w_e_d       = csr_refill | ~csr_ne;
                        end
                        OP_INV: begin
                            clear_vaddr_d = op_if.req_inv_vaddr;
                            clear_asid_d  = op_if.req_inv_asid;
                            if (op_if.req_inv_op <= 5'd6)
                                clear_mem_d = (op_if.req_inv_op == 5'd0) ? 3'd1 : op_if.req_inv_op[2:0];
                        end
                        default: ;
                    endcase
                end
            end
            S_EXEC: begin
                if (op_q > OP_INV) begin
                    state_d = S_IDLE;
                end else if (flush && (op_q == OP_SRCH || op_q == OP_RD)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d      = S_DONE;
                    done_valid_d = 1'b1;
                    done_op_d    = op_q;
                    done_hit_d   = (op_q == OP_SRCH || op_q == OP_RD) && tlb_rs_e;
                    done_index_d = (op_q == OP_SRCH) ? tlb_s_index : '0;
                    done_excp_d  = excp_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);

`ifdef TLB_FILL_LFSR_EN
        // x^8+x^6+x^5+x^4+1, free running
        fill_d = {fill_q[6:0], fill_q[7] ^ fill_q[5] ^ fill_q[4] ^ fill_q[3]};
`else
        fill_d = (state_q == S_EXEC && op_q == OP_FILL) ? fill_q + FW'(1) : fill_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            op_q          <= 3'd0;
            excp_q        <= 1'b0;
            we_q          <= 1'b0;
            fill_mode_q   <= 1'b0;
            w_index_q     <= '0;
            f_index_q     <= '0;
            w_e_q         <= 1'b0;
            r_index_q     <= '0;
            check_mode_q  <= 1'b0;
            s_vpn2_q      <= 19'd0;
            s_asid_q      <= 10'd0;
            clear_mem_q   <= 3'd0;
            clear_vaddr_q <= 32'd0;
            clear_asid_q  <= 10'd0;
            done_valid_q  <= 1'b0;
            done_op_q     <= 3'd0;
            done_hit_q    <= 1'b0;
            done_index_q  <= '0;
            done_excp_q   <= 1'b0;
`ifdef TLB_FILL_LFSR_EN
            fill_q        <= 8'h01;
`else
            fill_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            op_q          <= op_d;
            excp_q        <= excp_d;
            we_q          <= we_d;
            fill_mode_q   <= fill_mode_d;
            w_index_q     <= w_index_d;
            f_index_q     <= f_index_d;
            w_e_q         <= w_e_d;
            r_index_q     <= r_index_d;
            check_mode_q  <= check_mode_d;
            s_vpn2_q      <= s_vpn2_d;
            s_asid_q      <= s_asid_d;
            clear_mem_q   <= clear_mem_d;
            clear_vaddr_q <= clear_vaddr_d;
            clear_asid_q  <= clear_asid_d;
            done_valid_q  <= done_valid_d;
            done_op_q     <= done_op_d;
            done_hit_q    <= done_hit_d;
            done_index_q  <= done_index_d;
            done_excp_q   <= done_excp_d;
            fill_q        <= fill_d;
        end
    end

    assign op_if.req_ready  = req_ready_q;
    // A flush during DONE still cancels the SRCH/RD completion pulse.
    assign op_if.done_valid = done_valid_q & ~(flush & (done_op_q == OP_SRCH || done_op_q == OP_RD));
    assign op_if.done_op    = done_op_q;
    assign op_if.done_hit   = done_hit_q;
    assign op_if.done_index = done_index_q;
    assign op_if.done_excp  = done_excp_q;

    assign tlb_we          = we_q;
    assign tlb_fill_mode   = fill_mode_q;
    assign tlb_w_index     = w_index_q;
    assign tlb_f_index     = f_index_q;
    assign tlb_w_e         = w_e_q;
    assign tlb_r_index     = r_index_q;
    assign tlb_check_mode  = check_mode_q;
    assign tlb_s_vpn2      = s_vpn2_q;
    assign tlb_s_asid      = s_asid_q;
    assign tlb_clear_mem   = clear_mem_q;
    assign tlb_clear_vaddr = clear_vaddr_q;
    assign tlb_clear_asid  = clear_asid_q;
endmodule
